// File: rtl/pitch_match_scorer.sv
// Scores detected pitch periods against a snapshotted target/tolerance, keeps saturating
// hit/miss/streak statistics and raises locked after the programmed run of consecutive hits.
module pitch_match_scorer #(
  parameter int PERIOD_WIDTH = 20,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [31:0]             cfg_target,
  input  logic [31:0]             cfg_tolerance,
  input  logic [31:0]             cfg_hold,
  input  logic [31:0]             cfg_ctrl,
  input  logic [PERIOD_WIDTH-1:0] s_period_tdata,
  input  logic                    s_period_tvalid,
  output logic                    s_period_tready,
  output logic                    event_valid,
  output logic                    event_hit,
  output logic                    in_tune,
  output logic                    locked,
  output logic [CNT_WIDTH-1:0]    streak,
  output logic [CNT_WIDTH-1:0]    hit_count,
  output logic [CNT_WIDTH-1:0]    miss_count
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_TRACKING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [31:0]          TOL_MAX = 32'((64'd1 << PERIOD_WIDTH) - 64'd1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic                    enable_s, clear_s, enable_d_r, en_rise_s;
  logic [PERIOD_WIDTH-1:0] target_r, tol_r;
  logic [31:0]             hold_r;
  state_t                  state_r, state_nx_s;
  logic                    tready_r, tready_nx_s, locked_r, locked_nx_s;
  logic                    accept_s;
  logic [PERIOD_WIDTH:0]   diff_signed_s, diff_neg_s;
  logic [PERIOD_WIDTH-1:0] diff_mag_s, diff_r;
  logic                    s1_valid_r, s2_valid_r, s2_hit_r;
  logic                    ev_s, lock_hit_s;
  logic [32:0]             streak_inc_s;
  logic                    event_valid_r, event_hit_r, in_tune_r;
  logic [CNT_WIDTH-1:0]    streak_r, hit_count_r, miss_count_r;
  logic                    unused_bits_s;

  assign enable_s      = cfg_ctrl[0];
  assign clear_s       = cfg_ctrl[1];
  assign en_rise_s     = enable_s & ~enable_d_r;
  assign accept_s      = s_period_tvalid & tready_r;
  assign unused_bits_s = ^{cfg_ctrl[31:2], cfg_target[31:PERIOD_WIDTH]};

  // Signed difference one bit wider than the sample, then its magnitude.
  assign diff_signed_s = {1'b0, s_period_tdata} - {1'b0, target_r};
  assign diff_neg_s    = (~diff_signed_s) + {{PERIOD_WIDTH{1'b0}}, 1'b1};
  assign diff_mag_s    = diff_signed_s[PERIOD_WIDTH] ? diff_neg_s[PERIOD_WIDTH-1:0]
                                                     : diff_signed_s[PERIOD_WIDTH-1:0];

  assign ev_s         = s2_valid_r & enable_s;
  assign streak_inc_s = 33'(streak_r) + 33'd1;
  assign lock_hit_s   = (streak_inc_s >= {1'b0, hold_r});

  // Config snapshot taken only on the enable rising edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      enable_d_r <= 1'b0;
      target_r   <= {PERIOD_WIDTH{1'b0}};
      tol_r      <= {PERIOD_WIDTH{1'b0}};
      hold_r     <= 32'd1;
    end else begin
      enable_d_r <= enable_s;
      if (en_rise_s) begin
        target_r <= cfg_target[PERIOD_WIDTH-1:0];
        tol_r    <= (cfg_tolerance > TOL_MAX) ? {PERIOD_WIDTH{1'b1}}
                                              : cfg_tolerance[PERIOD_WIDTH-1:0];
        hold_r   <= (cfg_hold == 32'd0) ? 32'd1 : cfg_hold;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r <= ST_DISABLED;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state; disable outranks clear, clear outranks scoring.
  always_comb begin
    state_nx_s = state_r;
    if (!enable_s) begin
      state_nx_s = ST_DISABLED;
    end else if (clear_s) begin
      state_nx_s = ST_TRACKING;
    end else begin
      case (state_r)
        ST_DISABLED: state_nx_s = ST_TRACKING;
        ST_TRACKING: begin
          if (ev_s && s2_hit_r && lock_hit_s) state_nx_s = ST_LOCKED;
          else                                 state_nx_s = ST_TRACKING;
        end
        ST_LOCKED: begin
          if (ev_s && !s2_hit_r) state_nx_s = ST_TRACKING;
          else                   state_nx_s = ST_LOCKED;
        end
        default: state_nx_s = ST_DISABLED;
      endcase
    end
  end

  // FSM-derived outputs, registered below.
  always_comb begin
    tready_nx_s = enable_s & ~clear_s & (state_r != ST_DISABLED);
    locked_nx_s = (state_nx_s == ST_LOCKED);
  end

  // Handshake and lock flag registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tready_r <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      tready_r <= tready_nx_s;
      locked_r <= locked_nx_s;
    end
  end

  // Two-stage scoring pipeline, flushed whenever enable is low.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_hit_r   <= 1'b0;
      diff_r     <= {PERIOD_WIDTH{1'b0}};
    end else if (!enable_s) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) diff_r <= diff_mag_s;
      s2_valid_r <= s1_valid_r;
      s2_hit_r   <= (diff_r <= tol_r);
    end
  end

  // Event pulse and saturating statistics; clear wins over any increment.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      event_valid_r <= 1'b0;
      event_hit_r   <= 1'b0;
      in_tune_r     <= 1'b0;
      streak_r      <= {CNT_WIDTH{1'b0}};
      hit_count_r   <= {CNT_WIDTH{1'b0}};
      miss_count_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      event_valid_r <= ev_s;
      event_hit_r   <= ev_s & s2_hit_r;
      if (clear_s) begin
        in_tune_r    <= 1'b0;
        streak_r     <= {CNT_WIDTH{1'b0}};
        hit_count_r  <= {CNT_WIDTH{1'b0}};
        miss_count_r <= {CNT_WIDTH{1'b0}};
      end else if (!enable_s) begin
        streak_r <= {CNT_WIDTH{1'b0}};
      end else if (ev_s) begin
        in_tune_r <= s2_hit_r;
        if (s2_hit_r) begin
          streak_r    <= sat_inc(streak_r);
          hit_count_r <= sat_inc(hit_count_r);
        end else begin
          streak_r     <= {CNT_WIDTH{1'b0}};
          miss_count_r <= sat_inc(miss_count_r);
        end
      end
    end
  end

  assign s_period_tready = tready_r;
  assign event_valid     = event_valid_r;
  assign event_hit       = event_hit_r;
  assign in_tune         = in_tune_r;
  assign locked          = locked_r;
  assign streak          = streak_r;
  assign hit_count       = hit_count_r;
  assign miss_count      = miss_count_r;

endmodule

// File: tb/tb_pitch_match_scorer.sv
// Scoreboard bench for pitch_match_scorer: expected hit flags are queued at acceptance
// and compared when event_valid fires; statistics are checked at fixed points.
module tb_pitch_match_scorer;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] cfg_target = 32'd0, cfg_tolerance = 32'd0, cfg_hold = 32'd0, cfg_ctrl = 32'd0;
  logic [19:0] s_period_tdata = 20'd0;
  logic        s_period_tvalid = 1'b0;
  logic        s_period_tready, event_valid, event_hit, in_tune, locked;
  logic [15:0] streak, hit_count, miss_count;

  int total = 0;
  int bad = 0;
  bit exp_q[$];

  pitch_match_scorer #(.PERIOD_WIDTH(20), .CNT_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cfg_target(cfg_target), .cfg_tolerance(cfg_tolerance),
    .cfg_hold(cfg_hold), .cfg_ctrl(cfg_ctrl),
    .s_period_tdata(s_period_tdata), .s_period_tvalid(s_period_tvalid),
    .s_period_tready(s_period_tready),
    .event_valid(event_valid), .event_hit(event_hit), .in_tune(in_tune), .locked(locked),
    .streak(streak), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag, input logic [15:0] h, input logic [15:0] m,
                             input logic [15:0] s, input logic lk);
    check_eq({tag, "_hit"}, {16'd0, hit_count}, {16'd0, h});
    check_eq({tag, "_miss"}, {16'd0, miss_count}, {16'd0, m});
    check_eq({tag, "_streak"}, {16'd0, streak}, {16'd0, s});
    check_eq({tag, "_locked"}, {31'd0, locked}, {31'd0, lk});
  endtask

  // Scoreboard: every event must match the oldest outstanding expectation.
  always @(negedge ACLK) begin
    if (ARESETN && event_valid) begin
      if (exp_q.size() == 0) check_eq("unexpected_event", 32'd1, 32'd0);
      else check_eq("event_hit", {31'd0, event_hit}, {31'd0, exp_q.pop_front()});
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [19:0] d, input bit exp_hit, input bit track);
    int n = 0;
    s_period_tdata  = d;
    s_period_tvalid = 1'b1;
    while (!s_period_tready && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!s_period_tready) begin
      check_eq("tready_wait", {31'd0, s_period_tready}, 32'd1);
      s_period_tvalid = 1'b0;
    end else begin
      @(posedge ACLK);
      if (track) exp_q.push_back(exp_hit);
      @(negedge ACLK);
    end
  endtask

  task automatic idle(input int cycles);
    s_period_tvalid = 1'b0;
    repeat (cycles) @(negedge ACLK);
  endtask

  initial begin
    // Reset behaviour
    #100;
    check_eq("rst_flags", {27'd0, s_period_tready, event_valid, event_hit, in_tune, locked}, 32'd0);
    check_stats("rst", 16'd0, 16'd0, 16'd0, 1'b0);
    #100;
    ARESETN = 1'b1;
    cfg_target = 32'd1000; cfg_tolerance = 32'd5; cfg_hold = 32'd3;
    idle(3);
    check_eq("idle_tready", {31'd0, s_period_tready}, 32'd0);
    cfg_ctrl = 32'd1;
    @(negedge ACLK);
    check_eq("en_tready_1cyc", {31'd0, s_period_tready}, 32'd0);
    @(negedge ACLK);
    check_eq("en_tready_2cyc", {31'd0, s_period_tready}, 32'd1);

    // Three hits, both tolerance sides and the exact boundary, then lock
    send(20'd998, 1'b1, 1'b1);
    send(20'd1005, 1'b1, 1'b1);
    send(20'd1003, 1'b1, 1'b1);
    idle(1);
    check_stats("pre_lock", 16'd2, 16'd0, 16'd2, 1'b0);
    idle(1);
    check_stats("lock", 16'd3, 16'd0, 16'd3, 1'b1);
    check_eq("lock_in_tune", {31'd0, in_tune}, 32'd1);

    // Misses just outside tolerance on both sides, then a hit at the lower boundary
    send(20'd1006, 1'b0, 1'b1);
    idle(2);
    check_stats("miss1", 16'd3, 16'd1, 16'd0, 1'b0);
    check_eq("miss1_in_tune", {31'd0, in_tune}, 32'd0);
    send(20'd994, 1'b0, 1'b1);
    idle(2);
    check_eq("miss2_count", {16'd0, miss_count}, 32'd2);
    send(20'd995, 1'b1, 1'b1);
    idle(2);
    check_stats("low_edge", 16'd4, 16'd2, 16'd1, 1'b0);

    // Saturation under back-to-back traffic
    for (int i = 0; i < 70000; i++) send(20'd1000, 1'b1, 1'b1);
    idle(3);
    check_stats("sat", 16'hFFFF, 16'd2, 16'hFFFF, 1'b1);

    // Clear coinciding with a scored hit
    send(20'd1000, 1'b1, 1'b1);
    s_period_tvalid = 1'b0;
    @(negedge ACLK);
    cfg_ctrl = 32'd3;
    @(negedge ACLK);
    check_eq("clr_event", {31'd0, event_valid}, 32'd1);
    check_stats("clr", 16'd0, 16'd0, 16'd0, 1'b0);
    check_eq("clr_tready", {31'd0, s_period_tready}, 32'd0);
    @(negedge ACLK);
    check_eq("clr_tready_held", {31'd0, s_period_tready}, 32'd0);
    cfg_ctrl = 32'd1;
    @(negedge ACLK);
    check_eq("clr_release_tready", {31'd0, s_period_tready}, 32'd1);

    // Register write while enabled is not used until enable rises again
    cfg_target = 32'd2000;
    send(20'd2000, 1'b0, 1'b1);
    send(20'd1000, 1'b1, 1'b1);
    idle(3);
    check_stats("old_cfg", 16'd1, 16'd1, 16'd1, 1'b0);
    cfg_ctrl = 32'd0;
    @(negedge ACLK);
    check_stats("disabled", 16'd1, 16'd1, 16'd0, 1'b0);
    check_eq("dis_tready", {31'd0, s_period_tready}, 32'd0);
    cfg_tolerance = 32'd0;
    cfg_ctrl = 32'd1;
    send(20'd2000, 1'b1, 1'b1);
    send(20'd2001, 1'b0, 1'b1);
    idle(3);
    check_stats("new_cfg", 16'd2, 16'd2, 16'd0, 1'b0);

    // Enable drop with two samples in flight: no events, counters retained
    send(20'd2000, 1'b1, 1'b0);
    send(20'd2000, 1'b1, 1'b0);
    s_period_tvalid = 1'b0;
    cfg_ctrl = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check_eq("drop_no_event", {31'd0, event_valid}, 32'd0);
    end
    check_stats("drop", 16'd2, 16'd2, 16'd0, 1'b0);

    // Asynchronous reset with a sample in flight
    cfg_ctrl = 32'd1;
    send(20'd2000, 1'b1, 1'b0);
    s_period_tvalid = 1'b0;
    ARESETN = 1'b0;
    #1;
    check_eq("arst_flags", {27'd0, s_period_tready, event_valid, event_hit, in_tune, locked}, 32'd0);
    check_stats("arst", 16'd0, 16'd0, 16'd0, 1'b0);
    cfg_ctrl = 32'd0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check_eq("arst_no_event", {31'd0, event_valid}, 32'd0);
    end

    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
